// File: rtl/mlaccel_pkg.sv
// Shared constants and reader FSM encoding for the accelerator memory reader.
package mlaccel_pkg;

    localparam int unsigned MLACCEL_ADDR_W = 17;
    localparam int unsigned MLACCEL_DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2
    } reader_state_e;

endpackage

// File: rtl/mlaccel_reader_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Push and pop in the same cycle are legal even when full.
module mlaccel_reader_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 33,
    localparam int unsigned CntW = $clog2(DEPTH + 1),
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Pointer wrap and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful under a nonzero count.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mlaccel_memory_reader.sv
// Read initiator for the 128 KB accelerator memory port. Issues strided reads,
// absorbs the fixed read latency with a tag pipe and streams words out.
// Build option: MLACCEL_READER_STRIDE_EN honours cmd_stride_i; otherwise stride is 4.
module mlaccel_memory_reader
    import mlaccel_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [MLACCEL_ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]          cmd_len_i,
    input  logic [MLACCEL_ADDR_W-1:0] cmd_stride_i,
    output logic [MLACCEL_ADDR_W-1:0] mem_addr_o,
    output logic [3:0]                mem_wen_o,
    output logic [MLACCEL_DATA_W-1:0] mem_wdata_o,
    input  logic [MLACCEL_DATA_W-1:0] mem_rdata_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [MLACCEL_DATA_W-1:0] out_data_o,
    output logic                      out_last_o,
    output logic                      busy_o
);

    localparam int unsigned AW    = MLACCEL_ADDR_W;
    localparam int unsigned DW    = MLACCEL_DATA_W;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned InflW = $clog2(RD_LATENCY + 1);

    reader_state_e         state_q;
    logic [AW-1:0]         cur_addr_q;
    logic [AW-1:0]         mem_addr_q;
    logic [LEN_W-1:0]      remaining_q;
    logic [AW-1:0]         stride;
    logic [RD_LATENCY-1:0] tag_pipe_q, tag_pipe_d;
    logic [RD_LATENCY-1:0] last_pipe_q, last_pipe_d;
    logic [InflW-1:0]      inflight_q, inflight_d;
    logic [CntW-1:0]       fifo_count;
    logic [DW:0]           fifo_head;
    logic                  credit_ok, issue, push, pop, out_valid;

`ifdef MLACCEL_READER_STRIDE_EN
    logic [AW-1:0] stride_q;

    // Capture the per-command stride on acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stride_q <= '0;
        end else if (state_q == StIdle && cmd_valid_i) begin
            stride_q <= cmd_stride_i;
        end
    end

    assign stride = stride_q;
`else
    logic unused_stride;
    assign unused_stride = ^cmd_stride_i;
    assign stride        = AW'(4);
`endif

    // Words buffered plus reads in flight never exceed the buffer depth.
    assign credit_ok = (32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH;
    assign issue     = (state_q == StIssue) && credit_ok;
    assign push      = tag_pipe_q[RD_LATENCY-1];
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready_i;

    // Command FSM with address and length counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            mem_addr_q  <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        cur_addr_q  <= cmd_addr_i;
                        remaining_q <= cmd_len_i;
                        if (cmd_len_i != '0) begin
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (issue) begin
                        mem_addr_q  <= cur_addr_q;
                        cur_addr_q  <= cur_addr_q + stride;
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (pop && fifo_head[DW]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag pipe marks which cycles carry valid read data back from memory.
    always_comb begin
        tag_pipe_d     = '0;
        last_pipe_d    = '0;
        tag_pipe_d[0]  = issue;
        last_pipe_d[0] = issue && (remaining_q == LEN_W'(1));
        for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            tag_pipe_d[i]  = tag_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
        case ({issue, push})
            2'b10:   inflight_d = inflight_q + InflW'(1);
            2'b01:   inflight_d = inflight_q - InflW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Tag pipe and in-flight counter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_pipe_q  <= '0;
            last_pipe_q <= '0;
            inflight_q  <= '0;
        end else begin
            tag_pipe_q  <= tag_pipe_d;
            last_pipe_q <= last_pipe_d;
            inflight_q  <= inflight_d;
        end
    end

    mlaccel_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DW + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i ({last_pipe_q[RD_LATENCY-1], mem_rdata_i}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    assign cmd_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign mem_addr_o  = mem_addr_q;
    assign mem_wen_o   = 4'b0000;
    assign mem_wdata_o = '0;
    assign out_valid_o = out_valid;
    assign out_data_o  = fifo_head[DW-1:0];
    // Head storage is not reset, so gate last with valid.
    assign out_last_o  = out_valid && fifo_head[DW];

endmodule

// File: tb/tb_mlaccel_memory_reader.sv
// Directed bench for mlaccel_memory_reader with a latency-2 memory model
// whose word at byte address a is {a+3, a+2, a+1, a} (low address bytes).
module tb_mlaccel_memory_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [16:0] cmd_addr;
    logic [15:0] cmd_len;
    logic [16:0] cmd_stride;
    logic [16:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [31:0] q_data[$];
    logic        q_last[$];
    int          q_cyc[$];

    always #5 clk = ~clk;

    mlaccel_memory_reader dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .cmd_stride_i (cmd_stride),
        .mem_addr_o   (mem_addr),
        .mem_wen_o    (mem_wen),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .busy_o       (busy)
    );

    function automatic logic [31:0] pat(input logic [16:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // Memory: registered address plus one read register gives latency 2.
    logic [31:0] rdata_q = 32'h0;
    always @(posedge clk) rdata_q <= pat(mem_addr);
    assign mem_rdata = rdata_q;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output handshake, sampled mid low phase.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic send_cmd(input logic [16:0] a, input logic [15:0] l, input logic [16:0] s);
        int n = 0;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_len    = l;
        cmd_stride = s;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("cmd_accept_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int c);
        int k = 0;
        @(negedge clk);
        #2;
        while (!cmd_ready && k < 300) begin
            @(negedge clk);
            #2;
            k++;
        end
        check_eq("idle_timeout", 32'(k < 300), 32'd1);
        c = cyc;
    endtask

    task automatic check_words(input string tag, input logic [31:0] exp[$]);
        check_eq({tag, "_count"}, 32'(q_data.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < q_data.size()) begin
                check_eq({tag, "_data"}, q_data[i], exp[i]);
                check_eq({tag, "_last"}, 32'(q_last[i]), 32'(i == exp.size() - 1));
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int idle_c;
        int viol;
        int k;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_stride = 17'd4;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("mem_wen_tied", 32'(mem_wen), 32'd0);
        check_eq("mem_wdata_tied", mem_wdata, 32'd0);
        rst_n = 1'b1;

        // 1: aligned burst, full throughput
        clear_q();
        send_cmd(17'h00010, 16'd4, 17'd4);
        wait_idle(idle_c);
        check_words("t1", '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C});
        if (q_cyc.size() == 4) begin
            check_eq("t1_first_latency", 32'(q_cyc[0] - acc_cyc), 32'd3);
            check_eq("t1_back_to_back", 32'(q_cyc[3] - q_cyc[0]), 32'd3);
            check_eq("t1_ready_after_last", 32'(idle_c - q_cyc[3]), 32'd1);
        end

        // 2: unaligned start
        clear_q();
        send_cmd(17'h00003, 16'd2, 17'd4);
        wait_idle(idle_c);
        check_words("t2", '{32'h06050403, 32'h0A090807});

        // 3: backpressure; reads stall once four words are buffered or in flight
        clear_q();
        out_ready = 1'b0;
        send_cmd(17'h00020, 16'd8, 17'd4);
        repeat (10) @(negedge clk);
        #2;
        check_eq("t3_stall_addr", 32'(mem_addr), 32'h2C);
        check_eq("t3_hold_valid", 32'(out_valid), 32'd1);
        check_eq("t3_hold_data", out_data, 32'h23222120);
        check_eq("t3_hold_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        #2;
        check_eq("t3_stall_addr2", 32'(mem_addr), 32'h2C);
        check_eq("t3_hold_data2", out_data, 32'h23222120);
        k = 0;
        while (q_data.size() < 8 && k < 100) begin
            @(negedge clk);
            out_ready = (k % 2 == 0);
            k++;
        end
        out_ready = 1'b1;
        wait_idle(idle_c);
        check_words("t3", '{32'h23222120, 32'h27262524, 32'h2B2A2928, 32'h2F2E2D2C,
                            32'h33323130, 32'h37363534, 32'h3B3A3938, 32'h3F3E3D3C});

        // 4: address wrap at top of memory
        clear_q();
        send_cmd(17'h1FFFC, 16'd2, 17'd4);
        wait_idle(idle_c);
        check_words("t4", '{32'hFFFEFDFC, 32'h03020100});

        // 5a: zero-length command is a no-op
        clear_q();
        send_cmd(17'h00050, 16'd0, 17'd4);
        viol = 0;
        repeat (8) begin
            @(negedge clk);
            #2;
            if (!cmd_ready || out_valid || busy) viol++;
        end
        check_eq("t5_len0_violations", 32'(viol), 32'd0);
        check_eq("t5_len0_words", 32'(q_data.size()), 32'd0);

        // 5b: reset in the middle of a long command
        send_cmd(17'h00200, 16'd16, 17'd4);
        repeat (6) @(negedge clk);
        #3;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check_eq("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        check_eq("t5_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("t5_rst_mem_addr", 32'(mem_addr), 32'd0);
        #1;
        rst_n = 1'b1;
        clear_q();
        viol = 0;
        repeat (6) begin
            @(negedge clk);
            #2;
            if (out_valid || busy) viol++;
        end
        check_eq("t5_post_rst_quiet", 32'(viol), 32'd0);
        send_cmd(17'h00040, 16'd2, 17'd4);
        wait_idle(idle_c);
        check_words("t5", '{32'h43424140, 32'h47464544});

        // 6: stride option
        clear_q();
        send_cmd(17'h00100, 16'd3, 17'h00040);
        wait_idle(idle_c);
`ifdef MLACCEL_READER_STRIDE_EN
        check_words("t6", '{32'h03020100, 32'h43424140, 32'h83828180});
`else
        check_words("t6", '{32'h03020100, 32'h07060504, 32'h0B0A0908});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
